// File: rtl/uart_rx_collector.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_collector
// Description : UART receiver that deserialises 8N1 frames (8E1 when the
//               UART_RX_PARITY_EN macro is defined) from an asynchronous RX
//               pin. Received bytes are buffered in a first-word-fall-through
//               FIFO and presented as an AXI-Stream master on the core clock.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_collector #(
    parameter int unsigned CLK_FREQ_HZ = 16000000,
    parameter int unsigned BAUD_RATE   = 57600,
    parameter int unsigned FIFO_AW     = 4,
    parameter logic [7:0]  LAST_CHAR   = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overflow
);

    localparam int unsigned     c_DIV       = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned     c_CW        = $clog2(c_DIV);
    localparam logic [c_CW-1:0] c_LOAD_FULL = c_CW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_LOAD_HALF = c_CW'(c_DIV / 2 - 1);
    localparam int unsigned     c_DEPTH     = 2 ** FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY  = 3'd5
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rx_meta;
    logic                r_rx_s;
    logic [c_CW-1:0]     r_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_push_pend;
    logic [8:0]          r_push_data;
    logic                r_frame_err;
    logic                r_overflow;
    logic [FIFO_AW:0]    r_wr_ptr;
    logic [FIFO_AW:0]    r_rd_ptr;
    logic [8:0]          r_mem [c_DEPTH];
`ifdef UART_RX_PARITY_EN
    logic                r_par_err;
    logic                w_par_capture;
`endif

    logic                w_sample;
    logic                w_counting;
    logic                w_load_half;
    logic                w_shift;
    logic                w_push;
    logic                w_ferr;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_wr_en;
    logic                w_drop;
    logic [8:0]          w_head;

    assign w_sample = (r_cnt == '0);

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM next-state and per-cycle control strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_counting    = 1'b0;
        w_load_half   = 1'b0;
        w_shift       = 1'b0;
        w_push        = 1'b0;
        w_ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_capture = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_load_half = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_counting = 1'b1;
                if (w_sample) begin
                    // A start bit that is gone by mid-bit was only a glitch
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                w_counting = 1'b1;
                if (w_sample) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_counting = 1'b1;
                if (w_sample) begin
                    w_par_capture = 1'b1;
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_counting = 1'b1;
                if (w_sample) begin
                    if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_push = !r_par_err;
                        w_ferr = r_par_err;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        // Low stop bit: reject and wait out a possible break
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Baud counter, bit index, shift register and push/error staging
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push_pend <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            if (w_load_half) begin
                r_cnt <= c_LOAD_HALF;
            end else if (w_counting) begin
                r_cnt <= w_sample ? c_LOAD_FULL : r_cnt - c_CW'(1);
            end
            if (r_state == S_START) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
`ifdef UART_RX_PARITY_EN
            if (w_par_capture) begin
                r_par_err <= (^r_shift) ^ r_rx_s;
            end
`endif
            r_push_pend <= w_push;
            if (w_push) begin
                r_push_data <= {(r_shift == LAST_CHAR), r_shift};
            end
            r_frame_err <= w_ferr;
        end
    end

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                      (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_pop    = !w_empty && i_tready;
    // A pop in the same cycle frees the slot the push is about to reuse
    assign w_wr_en  = r_push_pend && (!w_full || w_pop);
    assign w_drop   = r_push_pend && w_full && !w_pop;
    assign w_head   = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    // FIFO storage: 9-bit entries of {tlast, tdata}
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_push_data;
        end
    end

    // FIFO pointers and overflow pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_overflow <= w_drop;
        end
    end

    // Head entry is masked to zero while empty so outputs are clean after reset
    assign o_tvalid    = !w_empty;
    assign o_tdata     = w_empty ? 8'h00 : w_head[7:0];
    assign o_tlast     = w_empty ? 1'b0  : w_head[8];
    assign o_frame_err = r_frame_err;
    assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_collector
// Description : Self-checking bench for uart_rx_collector (DIV=10, depth 4).
//               Expected bytes are queued when frames are driven and checked
//               as the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_collector;

    localparam int unsigned c_DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    logic       tvalid;
    logic       frame_err;
    logic       overflow;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_ferr   = 0;
    int         n_ovf    = 0;
    int         n_valid  = 0;
    int         n_pop    = 0;
    logic [8:0] sb_q[$];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_head  = '0;

    always #5 clk = ~clk;

    uart_rx_collector #(
        .CLK_FREQ_HZ (1000000),
        .BAUD_RATE   (100000),
        .FIFO_AW     (2),
        .LAST_CHAR   (8'h0A)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uart_rx   (uart_rx),
        .o_tdata     (tdata),
        .o_tlast     (tlast),
        .o_tvalid    (tvalid),
        .i_tready    (tready),
        .o_frame_err (frame_err),
        .o_overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_time(input logic v);
        uart_rx = v;
        idle(c_DIV);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        sb_q.push_back({(b == 8'h0A), b});
    endtask

    // stop_low > 0 holds the line low that many cycles in place of the stop bit
    task automatic send_frame(input logic [7:0] b, input logic par, input int stop_low);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(par);
`endif
        if (stop_low > 0) begin
            uart_rx = 1'b0;
            idle(stop_low);
        end
        bit_time(1'b1);
        bit_time(1'b1);
    endtask

    // Output monitor: pulse counters, hold-stability and scoreboard checks
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_err) n_ferr++;
            if (overflow)  n_ovf++;
            if (tvalid)    n_valid++;
            if (prev_stall) begin
                chk("hold_valid", 32'(tvalid), 32'(1'b1));
                chk("hold_head", 32'({tlast, tdata}), 32'(prev_head));
            end
            if (tvalid && tready) begin
                chk("sb_has_entry", 32'(sb_q.size() != 0), 32'(1'b1));
                if (sb_q.size() != 0) begin
                    chk("rx_byte", 32'({tlast, tdata}), 32'(sb_q.pop_front()));
                end
                n_pop++;
            end
            prev_stall = tvalid && !tready;
            prev_head  = {tlast, tdata};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, f0, o0, p0;
        rst     = 1'b1;
        uart_rx = 1'b1;
        tready  = 1'b0;
        idle(3);
        @(negedge clk);
        chk("rst_tvalid", 32'(tvalid), 32'(1'b0));
        chk("rst_tdata", 32'(tdata), 32'(8'h00));
        chk("rst_tlast", 32'(tlast), 32'(1'b0));
        chk("rst_frame_err", 32'(frame_err), 32'(1'b0));
        chk("rst_overflow", 32'(overflow), 32'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle(20);

        // Single byte with the sink always ready
        tready = 1'b1;
        v0 = n_valid; f0 = n_ferr; o0 = n_ovf;
        expect_byte(8'hA5);
        send_frame(8'hA5, ^8'hA5, 0);
        idle(10);
        chk("a5_valid_cycles", 32'(n_valid - v0), 32'd1);
        chk("a5_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("a5_no_ovf", 32'(n_ovf - o0), 32'd0);
        chk("a5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Three bytes queued behind a stalled sink, then drained back-to-back
        tready = 1'b0;
        expect_byte(8'h48);
        expect_byte(8'h69);
        expect_byte(8'h0A);
        send_frame(8'h48, ^8'h48, 0);
        send_frame(8'h69, ^8'h69, 0);
        send_frame(8'h0A, ^8'h0A, 0);
        idle(10);
        @(negedge clk);
        chk("hi_head_data", 32'(tdata), 32'(8'h48));
        chk("hi_head_last", 32'(tlast), 32'(1'b0));
        @(posedge clk); #1;
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hi_drain_valid", 32'(tvalid), 32'(1'b1));
        end
        @(negedge clk);
        chk("hi_drained", 32'(tvalid), 32'(1'b0));
        chk("hi_sb_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;

        // Low stop bit followed by a held-low line, then a good byte
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, ^8'h3C, 30);
        idle(5);
        chk("brk_ferr", 32'(n_ferr - f0), 32'd1);
        chk("brk_no_output", 32'(n_valid - v0), 32'd0);
        expect_byte(8'h11);
        send_frame(8'h11, ^8'h11, 0);
        idle(10);
        chk("brk_next_byte", 32'(n_valid - v0), 32'd1);
        chk("brk_sb_empty", 32'(sb_q.size()), 32'd0);

        // Short low glitch on an idle line
        v0 = n_valid; f0 = n_ferr;
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(30);
        chk("glitch_no_output", 32'(n_valid - v0), 32'd0);
        chk("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);
        expect_byte(8'h5A);
        send_frame(8'h5A, ^8'h5A, 0);
        idle(10);
        chk("glitch_recover", 32'(sb_q.size()), 32'd0);

        // Five bytes into a depth-4 FIFO with the sink stalled
        tready = 1'b0;
        o0 = n_ovf; p0 = n_pop;
        for (int i = 1; i <= 4; i++) expect_byte(8'(i));
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), ^8'(i), 0);
            if (i == 4) chk("ovf_none_yet", 32'(n_ovf - o0), 32'd0);
        end
        idle(5);
        chk("ovf_pulse", 32'(n_ovf - o0), 32'd1);
        tready = 1'b1;
        idle(10);
        chk("ovf_drain_count", 32'(n_pop - p0), 32'd4);
        chk("ovf_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of the data bits aborts the frame silently
        v0 = n_valid; f0 = n_ferr;
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        rst     = 1'b1;
        uart_rx = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(30);
        chk("rst_mid_no_output", 32'(n_valid - v0), 32'd0);
        chk("rst_mid_no_ferr", 32'(n_ferr - f0), 32'd0);
        expect_byte(8'h7E);
        send_frame(8'h7E, ^8'h7E, 0);
        idle(10);
        chk("rst_mid_7e", 32'(n_valid - v0), 32'd1);
        chk("rst_mid_sb_empty", 32'(sb_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Bad parity is rejected; good parity is delivered
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h03, 1'b1, 0);
        idle(5);
        chk("par_bad_ferr", 32'(n_ferr - f0), 32'd1);
        chk("par_bad_no_output", 32'(n_valid - v0), 32'd0);
        expect_byte(8'h03);
        send_frame(8'h03, 1'b0, 0);
        idle(10);
        chk("par_good_output", 32'(n_valid - v0), 32'd1);
        chk("par_good_ferr", 32'(n_ferr - f0), 32'd1);
`endif

        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_collector.md
Name: uart_rx_collector

Overview:
- UART receiver: the inbound counterpart of the corescore emitter.
- Deserialises 8N1 frames from a board RX pin and buffers bytes in a small FIFO.
- Presents bytes as an AXI-Stream master (tdata/tlast/tvalid/tready) on the core clock.
- Used for host-to-board command input and for loopback checking of emitter output on boards with an RX line.

Parameters:
- CLK_FREQ_HZ, 16000000, core clock frequency.
- BAUD_RATE, 57600, line rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer, must be >= 4).
- FIFO_AW, 4, log2 of FIFO depth (depth = 2**FIFO_AW bytes).
- LAST_CHAR, 8'h0A, byte value that asserts o_tlast.

Ports:
- i_clk  input  1  core clock, the only clock.
- i_rst  input  1  synchronous, active-high reset.
- i_uart_rx  input  1  asynchronous serial line, idle high.
- o_tdata  output  8  received byte.
- o_tlast  output  1  high when o_tdata == LAST_CHAR.
- o_tvalid  output  1  byte available.
- i_tready  input  1  downstream accepts byte.
- o_frame_err  output  1  one-cycle pulse when a frame is rejected.
- o_overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Interface: one clock (i_clk); reset i_rst is synchronous and active-high.
- Reset values: o_tvalid=0, o_tdata=0, o_tlast=0, o_frame_err=0, o_overflow=0; FIFO empty; FSM in IDLE; synchroniser flops set to 1.
- Reset mid-frame aborts the frame with no output and no error pulse.
- Synchroniser: i_uart_rx passes through 2 flops; all decoding uses the synchronised bit rx_s.
- Baud counter: counts down from its load value; sampling occurs on the cycle the count reaches 0, then it reloads DIV-1.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on rx_s==0, load counter with DIV/2-1, go to START.
- START: at sample, if rx_s==1 treat as a glitch and return to IDLE with no error; else load DIV-1, set bit index 0, go to DATA.
- DATA: at each sample, shift rx_s into bit [7] of the shift register (LSB first). After the 8th sample go to STOP.
- STOP: at sample, if rx_s==1, push the byte and go to IDLE.
- STOP, rx_s==0 at sample: pulse o_frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: remain until rx_s==1 (break handling), then IDLE.
- FIFO push: occurs in the cycle after the stop sample.
  - If the FIFO is full and a pop occurs in that same cycle, the push succeeds.
  - If the FIFO is full and no pop occurs, the byte is dropped and o_overflow pulses for one cycle.
- Output is first-word-fall-through: o_tvalid rises the cycle after a push into an empty FIFO.
- Pin-to-valid latency: 2 cycles of synchroniser + frame time + 2 cycles.
- While o_tvalid=1 and i_tready=0, o_tdata and o_tlast are held stable.
- A transfer happens when o_tvalid & i_tready; the next entry is presented in the following cycle.
- Simultaneous push and pop on an empty FIFO: the pushed byte appears the next cycle, with no bypass.
- o_tlast is computed at push time and stored in the FIFO alongside the byte (9-bit entries).
- FIFO pointers are FIFO_AW+1 bits, so full and empty are distinguished by the MSB; pointer wrap is natural.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1.
  - After DATA, an additional PARITY state samples one bit.
  - XOR of the 8 data bits and the parity bit must equal 0; if not, pulse o_frame_err, discard the byte, and still sample the stop bit before IDLE/WAIT_IDLE.
- Undefined: 8N1 with no parity state; the rest of the logic is identical.

Test Plan:
- All scenarios use CLK_FREQ_HZ=1000000, BAUD_RATE=100000 (DIV=10).
- Byte 8'hA5 sent with i_tready=1 -> o_tvalid pulses one cycle, o_tdata=8'hA5, o_tlast=0; no error pulses.
- Bytes "H","i",8'h0A sent with i_tready=0 -> three entries queued; on raising i_tready they drain over 3 consecutive cycles as 8'h48, 8'h69, 8'h0A, with o_tlast=1 only on 8'h0A.
- Stop bit forced low on byte 8'h3C, line held low 30 cycles, then byte 8'h11 -> one o_frame_err pulse, no 8'h3C output, then 8'h11 delivered.
- 3-cycle low glitch on idle line -> no output, no error, FSM back in IDLE.
- FIFO_AW=2, i_tready=0, 5 bytes 8'h01..8'h05 sent -> o_overflow pulses once (on byte 8'h05); drain yields 8'h01..8'h04.
- Assert i_rst for 1 cycle mid-DATA of a byte, then send 8'h7E -> only 8'h7E delivered.
- With UART_RX_PARITY_EN: 8'h03 with parity 1 -> o_frame_err, no output; 8'h03 with parity 0 -> delivered.
